// File: rtl/fetch_pkg.sv
// Shared types for the miniRISC fetch stage: FSM state, prefetch depth and
// the prefetch entry layout (fetch PC plus instruction word).
package fetch_pkg;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch buffer. The head is always entries[0] so the outputs
// come straight from a register and stay stable while decode stalls.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fifo_entry_t data,
  output logic [1:0]  count,
  output fifo_entry_t head
);

  fifo_entry_t entries [FIFO_DEPTH];
  logic        pop_ok;

  assign pop_ok = pop && (count != 2'd0);
  assign head   = entries[0];

  // A pop in the flush cycle is already consumed downstream; clearing the
  // count covers both, and any response arriving in that cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 2'd0;
      entries[0] <= '0;
      entries[1] <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count == 2'd0) entries[0] <= data;
          else               entries[1] <= data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entries[0] <= entries[1];
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entries[0] <= data;
          end else begin
            entries[0] <= entries[1];
            entries[1] <= data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives a 1-cycle synchronous imem, buffers into a
// 2-entry prefetch FIFO. Optional stats counters built when FETCH_STATS_EN is defined.
//
// state | meaning
// BOOT  | single cycle after reset, no fetch issued
// RUN   | fetching under the credit/redirect issue rule
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        flush_cnt
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  tag_pc;
  logic [31:0]  issue_pc;
  logic         issued_q;
  logic         redirect_q;
  logic         inflight;
  logic         pop;
  logic         push;
  logic [1:0]   occ;
  logic [2:0]   projected;
  fifo_entry_t  fifo_in;
  fifo_entry_t  head;

  assign inflight    = issued_q && !redirect_q;
  assign instr_valid = (occ != 2'd0);
  assign pop         = instr_valid && instr_ready;

  // pop implies occ >= 1, so this never underflows
  assign projected = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign imem_en   = (state == RUN) && !halt && (redirect_valid || (projected < 3'd2));
  assign issue_pc  = redirect_valid ? redirect_pc : pc;
  assign imem_addr = imem_en ? issue_pc[IMEM_AW+1:2] : '0;

  // The response landing in a redirect cycle belongs to the squashed path.
  assign push          = issued_q && !redirect_valid;
  assign fifo_in.pc    = tag_pc;
  assign fifo_in.instr = imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      tag_pc     <= '0;
      issued_q   <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state      <= RUN;
      issued_q   <= imem_en;
      redirect_q <= redirect_valid;
      if (imem_en) tag_pc <= issue_pc;
      if (redirect_valid) pc <= imem_en ? redirect_pc + 32'd4 : redirect_pc;
      else if (imem_en)   pc <= pc + 32'd4;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .data  (fifo_in),
    .count (occ),
    .head  (head)
  );

  assign instr    = head.instr;
  assign instr_pc = head.pc;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pop)            fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect_valid) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected fetch PCs are queued per
// scenario and matched against every decode handshake by a negedge monitor.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;

`ifdef FETCH_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int pop_model = 0;
  int flush_model = 0;
  logic [31:0] exp_q[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0100), .IMEM_AW(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  // memory word i holds 0xA000_0000 + i
  always @(posedge clk) if (imem_en) imem_rdata <= 32'hA000_0000 + {22'b0, imem_addr};

  function automatic logic [31:0] word_at(input logic [31:0] p);
    return 32'hA000_0000 + {22'b0, p[11:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_imem_en",     {31'b0, imem_en},     32'd0);
    check("rst_imem_addr",   {22'b0, imem_addr},   32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr",       instr,                32'd0);
    check("rst_instr_pc",    instr_pc,             32'd0);
    check("rst_fetch_cnt",   fetch_cnt,            32'd0);
    check("rst_flush_cnt",   flush_cnt,            32'd0);
  endtask

  task automatic check_stats();
    check("fetch_cnt", fetch_cnt, STATS_EN ? 32'(pop_model) : 32'd0);
    check("flush_cnt", flush_cnt, STATS_EN ? 32'(flush_model) : 32'd0);
  endtask

  task automatic check_en(input string tag, input logic en, input logic [9:0] addr);
    check({tag, "_en"}, {31'b0, imem_en}, {31'b0, en});
    if (en) check({tag, "_addr"}, {22'b0, imem_addr}, {22'b0, addr});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid && instr_ready) begin
        pop_model++;
        check("pop_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("deliver_pc",    instr_pc, e);
          check("deliver_instr", instr,    word_at(e));
        end
      end
      if (redirect_valid) flush_model++;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #3;
    check_reset_values();

    // Epoch 1: free-running fetch with decode always ready
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(4 * i));
    @(posedge clk); #1;
    rst = 1'b0;                                   // cycle 0 (BOOT)
    #1 check_en("c0", 1'b0, 10'h0);
    tick(); #1 check_en("c1", 1'b1, 10'h040);
    check("c1_valid", {31'b0, instr_valid}, 32'd0);
    tick(); #1 check_en("c2", 1'b1, 10'h041);
    check("c2_valid", {31'b0, instr_valid}, 32'd0);
    for (int c = 3; c <= 10; c++) begin
      tick(); #1 check("stream_valid", {31'b0, instr_valid}, 32'd1);
    end
    check_stats();

    // Asynchronous reset mid-stream
    tick();
    check("epoch1_drained", 32'(exp_q.size()), 32'd0);
    #2 rst = 1'b1;
    #1 check_reset_values();
    pop_model   = 0;
    flush_model = 0;

    // Epoch 2: backpressure, redirects, halt
    instr_ready = 1'b0;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
    exp_q.push_back(32'h20C); exp_q.push_back(32'h210);
    exp_q.push_back(32'h300); exp_q.push_back(32'h304);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h400 + 32'(4 * i));
    tick();
    rst = 1'b0;                                   // cycle 0
    #1 check_en("e2c0", 1'b0, 10'h0);
    check_stats();
    tick(); #1 check_en("e2c1", 1'b1, 10'h040);
    tick(); #1 check_en("e2c2", 1'b1, 10'h041);
    for (int c = 3; c <= 6; c++) begin
      tick(); #1 check_en("stall", 1'b0, 10'h0);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_pc",    instr_pc, 32'h100);
      check("stall_instr", instr,    word_at(32'h100));
    end
    tick(); instr_ready = 1'b1;                   // c7
    #1 check_en("resume1", 1'b1, 10'h042);
    tick(); #1 check_en("resume2", 1'b1, 10'h043);
    tick(); instr_ready = 1'b0;                   // c9
    #1 check_en("refill", 1'b0, 10'h0);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h200;   // c10
    #1 check_en("redir", 1'b1, 10'h080);
    check("redir_head", instr_pc, 32'h108);
    tick(); redirect_valid = 1'b0;                // c11
    #1 check("redir_gap_valid", {31'b0, instr_valid}, 32'd0);
    check_en("redir_next", 1'b1, 10'h081);
    tick(); #1 check("redir_first_valid", {31'b0, instr_valid}, 32'd1);   // c12
    check("redir_first_pc", instr_pc, 32'h200);
    tick(); instr_ready = 1'b1;                   // c13
    #1 check_en("pre_halt", 1'b1, 10'h082);
    tick(); halt = 1'b1;                          // c14..c18
    #1 check_en("halt0", 1'b0, 10'h0);
    for (int c = 15; c <= 18; c++) begin
      tick(); #1 check_en("halt", 1'b0, 10'h0);
    end
    check("halt_drained", {31'b0, instr_valid}, 32'd0);
    tick(); halt = 1'b0;                          // c19
    #1 check_en("unhalt1", 1'b1, 10'h083);
    tick(); #1 check_en("unhalt2", 1'b1, 10'h084);
    tick(); #1 check_en("unhalt3", 1'b1, 10'h085);
    check("unhalt_pc", instr_pc, 32'h20C);
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h300;   // c22: redirect + pop
    #1 check("redir_pop_head", instr_pc, 32'h210);
    check_en("redir_pop", 1'b1, 10'h0C0);
    tick(); redirect_valid = 1'b0;                // c23
    #1 check("redir_pop_gap", {31'b0, instr_valid}, 32'd0);
    check_en("redir_pop_next", 1'b1, 10'h0C1);
    tick(); #1 check("redir_pop_first", instr_pc, 32'h300);   // c24
    tick(); halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;   // c25
    #1 check_en("halt_redir", 1'b0, 10'h0);
    tick(); redirect_valid = 1'b0;                // c26
    #1 check_en("halt_redir_hold1", 1'b0, 10'h0);
    check("halt_redir_valid", {31'b0, instr_valid}, 32'd0);
    tick(); #1 check_en("halt_redir_hold2", 1'b0, 10'h0);
    tick(); halt = 1'b0;                          // c28
    #1 check_en("halt_redir_target", 1'b1, 10'h100);
    tick(); #1 check_en("halt_redir_next", 1'b1, 10'h101);
    for (int c = 30; c <= 33; c++) begin
      tick(); #1 check("final_valid", {31'b0, instr_valid}, 32'd1);
    end
    tick(); instr_ready = 1'b0;                   // c34
    #1 check("epoch2_drained", 32'(exp_q.size()), 32'd0);
    check_stats();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
